// File: rtl/level_sync_debounce.sv
// rtl/level_sync_debounce.sv - synchronise and debounce an asynchronous level, with rise/fall event pulses
module level_sync_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level_out,
  output logic rise_evt,
  output logic fall_evt,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value at which the next mismatching cycle completes qualification.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  state_t                 state_q, state_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  // Only the last synchroniser stage is ever looked at by the debouncer.
  assign s = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous input into the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
  end

  // Debounce: any cycle where s agrees with level_out wipes all progress.
  always_comb begin
    cnt_d   = '0;
    state_d = STABLE;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = QUALIFY;
      end
    end
  end

  // State registers; reset overrides everything and discards any pending transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q   <= '0;
      state_q <= STABLE;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out = level_q;
  assign rise_evt  = rise_q;
  assign fall_evt  = fall_q;
  assign busy      = (state_q == QUALIFY);

endmodule

// File: tb/tb_level_sync_debounce.sv
// tb/tb_level_sync_debounce.sv - directed scoreboard bench for level_sync_debounce
module tb_level_sync_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic a_in, b_in;
  logic a_lvl, a_rise, a_fall, a_busy;
  logic b_lvl, b_rise, b_fall, b_busy;

  // Default configuration.
  level_sync_debounce #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .RESET_LEVEL(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .async_in(a_in),
    .level_out(a_lvl), .rise_evt(a_rise), .fall_evt(a_fall), .busy(a_busy)
  );

  // Deeper synchroniser, single-cycle debounce.
  level_sync_debounce #(
    .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .async_in(b_in),
    .level_out(b_lvl), .rise_evt(b_rise), .fall_evt(b_fall), .busy(b_busy)
  );

  typedef struct packed {
    logic lvl;
    logic rise;
    logic fall;
    logic busy;
  } obs_t;

  obs_t exp_q[$];
  obs_t plan[0:63];
  logic in_plan[0:63];
  int   tests = 0;
  int   fails = 0;

  function automatic obs_t observe(input int sel);
    obs_t o;
    if (sel == 0) o = '{a_lvl, a_rise, a_fall, a_busy};
    else          o = '{b_lvl, b_rise, b_fall, b_busy};
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s got lvl/rise/fall/busy=%b required=%b", tag, got, exp);
    end
  endtask

  // Steady expectation: input and level both at lvl, nothing happening.
  task automatic plan_init(input int len, input logic lvl);
    for (int j = 0; j < len; j++) begin
      plan[j]    = '{lvl, 1'b0, 1'b0, 1'b0};
      in_plan[j] = lvl;
    end
  endtask

  // Input held at v for w cycles starting at capture index start (relative to edge k).
  // Expected behaviour from the documented latency: busy from start+n for D-1 cycles
  // (or for w cycles if the segment is too short), flip at start+n+d-1.
  task automatic plan_seg(input int start, input int w, input int n, input int d,
                          input logic v, input int len);
    for (int j = start; j < start + w && j < len; j++) in_plan[j] = v;
    if (w >= d) begin
      for (int j = start + n; j <= start + n + d - 2 && j < len; j++) plan[j].busy = 1'b1;
      if (start + n + d - 1 < len) begin
        plan[start + n + d - 1].rise = v;
        plan[start + n + d - 1].fall = ~v;
      end
      for (int j = start + n + d - 1; j < len; j++) plan[j].lvl = v;
    end else begin
      for (int j = start + n; j <= start + n + w - 1 && j < len; j++) plan[j].busy = 1'b1;
    end
  endtask

  // Entered and left at a negedge: drive input, let one posedge pass, sample.
  task automatic run_plan(input int sel, input int len, input string tag);
    obs_t e;
    for (int j = 0; j < len; j++) exp_q.push_back(plan[j]);
    for (int j = 0; j < len; j++) begin
      if (sel == 0) a_in = in_plan[j];
      else          b_in = in_plan[j];
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", tag, j), observe(sel), e);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_in  = 1'b1;
    b_in  = 1'b0;
    @(negedge clk);

    // 1. Reset held with async_in high: everything at reset level.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("reset_a[%0d]", i), observe(0), '{1'b0, 1'b0, 1'b0, 1'b0});
      check($sformatf("reset_b[%0d]", i), observe(1), '{1'b0, 1'b0, 1'b0, 1'b0});
    end
    reset = 1'b0;
    plan_init(20, 1'b0);
    plan_seg(0, 20, 2, 8, 1'b1, 20);
    run_plan(0, 20, "rst_release");

    // 5. Fall from 1.
    plan_init(20, 1'b1);
    plan_seg(0, 20, 2, 8, 1'b0, 20);
    run_plan(0, 20, "fall");

    // 2. Clean rising step.
    plan_init(20, 1'b0);
    plan_seg(0, 20, 2, 8, 1'b1, 20);
    run_plan(0, 20, "step");

    // Back to 0 before the glitch tests.
    plan_init(20, 1'b1);
    plan_seg(0, 20, 2, 8, 1'b0, 20);
    run_plan(0, 20, "fall_b");

    // 3. Five-cycle glitch rejected.
    plan_init(12, 1'b0);
    plan_seg(0, 5, 2, 8, 1'b1, 12);
    run_plan(0, 12, "glitch");

    // 4. Bounce: 1x4, 0x2, then 1 held.
    plan_init(30, 1'b0);
    plan_seg(0, 4, 2, 8, 1'b1, 30);
    plan_seg(6, 24, 2, 8, 1'b1, 30);
    run_plan(0, 30, "bounce");

    // Back to 0 before the mid-qualify reset.
    plan_init(20, 1'b1);
    plan_seg(0, 20, 2, 8, 1'b0, 20);
    run_plan(0, 20, "fall_c");

    // 6. Reset once the counter has reached 4.
    plan_init(6, 1'b0);
    plan_seg(0, 6, 2, 8, 1'b1, 6);
    run_plan(0, 6, "pre_reset");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset", observe(0), '{1'b0, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;
    plan_init(4, 1'b0);
    run_plan(0, 4, "post_reset");

    // Second configuration: steps 2 and 5 with latency k+3, busy never set.
    plan_init(10, 1'b0);
    plan_seg(0, 10, 3, 1, 1'b1, 10);
    run_plan(1, 10, "b_step");
    plan_init(10, 1'b1);
    plan_seg(0, 10, 3, 1, 1'b0, 10);
    run_plan(1, 10, "b_fall");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
